// File: rtl/fp32_dot_acc.sv
// FP32 dot-product accumulator: takes one alpha*bravo element per IDLE visit and adds
// it to a running sum over a multi-cycle CALC window. After VEC_LEN elements it presents the result on delta.
module fp32_dot_acc #(
   parameter int VEC_LEN   = 4,
   parameter int CALC_WAIT = 433,
   localparam int CNT_W    = $clog2(VEC_LEN + 1)
) (
   input  logic             CLK_I,
   input  logic             RSTL_I,
   input  logic [31:0]      alpha,
   input  logic [31:0]      bravo,
   input  logic [31:0]      ACC_INIT_I,
   input  logic             ACC_SEL_I,
   input  logic             MAC_VALID_I,
   output logic             MAC_READY_O,
   output logic [31:0]      delta,
   output logic             MAC_VALID_O,
   input  logic             MAC_READY_I,
   output logic [CNT_W-1:0] ELEM_CNT_O
);

   localparam int          WAIT_W = $clog2(CALC_WAIT + 1);
   localparam logic [31:0] QNAN   = 32'h7FC00000;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic              ready_q, valid_q;
   logic [31:0]       alpha_q, bravo_q, acc_op_q, acc_q, delta_q;
   logic [31:0]       prod, acc_next;
   logic [CNT_W-1:0]  cnt_q;
   logic [WAIT_W-1:0] wait_q;
   logic              accept, calc_last, last_elem;

   // Round-to-nearest-even multiply; subnormal inputs and results flush to zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st, rnd;
      logic [47:0] p;
      logic [22:0] m;
      logic [24:0] mr;
      int          e;
      s      = a[31] ^ b[31];
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m  = p[46:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 1;
      end else begin
         m  = p[45:23];
         g  = p[22];
         st = |p[21:0];
      end
      rnd = g & (st | m[0]);
      mr  = {2'b01, m} + {24'd0, rnd};
      if (mr[24]) begin
         e = e + 1;
         m = mr[23:1];
      end else begin
         m = mr[22:0];
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], m};
   endfunction

   // Round-to-nearest-even add with guard/round/sticky bits; exact cancellation gives +0.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [27:0] mx, my, sum;
      logic [24:0] mr;
      logic [22:0] frac;
      logic        a_nan, b_nan, a_inf, b_inf, st, rnd;
      int          d, e;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return QNAN;
      if (a_inf) return a;
      if (b_inf) return b;
      if ((a[30:23] == 8'h00) && (b[30:23] == 8'h00)) return {a[31] & b[31], 31'd0};
      if (a[30:23] == 8'h00) return b;
      if (b[30:23] == 8'h00) return a;
      if (b[30:0] > a[30:0]) begin
         x = b;
         y = a;
      end else begin
         x = a;
         y = b;
      end
      mx = {2'b01, x[22:0], 3'b000};
      my = {2'b01, y[22:0], 3'b000};
      d  = int'(x[30:23]) - int'(y[30:23]);
      if (d > 26) begin
         my = 28'd1;
      end else begin
         st = |(my & ((28'd1 << d) - 28'd1));
         my = (my >> d) | {27'd0, st};
      end
      sum = (x[31] == y[31]) ? (mx + my) : (mx - my);
      if (sum == 28'd0) return 32'h0000_0000;
      e = int'(x[30:23]);
      if (sum[27]) begin
         sum = {1'b0, sum[27:2], sum[1] | sum[0]};
         e   = e + 1;
      end
      for (int i = 0; i < 26; i++) begin
         if (!sum[26]) begin
            sum = sum << 1;
            e   = e - 1;
         end
      end
      rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
      mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
      if (mr[24]) begin
         e    = e + 1;
         frac = mr[23:1];
      end else begin
         frac = mr[22:0];
      end
      if (e >= 255) return {x[31], 8'hFF, 23'd0};
      if (e <= 0) return {x[31], 31'd0};
      return {x[31], e[7:0], frac};
   endfunction

   assign accept    = MAC_VALID_I && ready_q;
   assign calc_last = (wait_q == WAIT_W'(CALC_WAIT - 1));
   assign last_elem = (cnt_q == CNT_W'(VEC_LEN - 1));

   always_comb begin
      prod     = fp_mul(alpha_q, bravo_q);
      acc_next = fp_add(acc_op_q, prod);
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (calc_last) state_d = last_elem ? DONE : IDLE;
         DONE:    if (MAC_READY_I) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
         valid_q <= (state_d == DONE);
      end
   end

   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
         alpha_q  <= 32'd0;
         bravo_q  <= 32'd0;
         acc_op_q <= 32'd0;
         acc_q    <= 32'd0;
         delta_q  <= 32'd0;
         cnt_q    <= '0;
         wait_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  alpha_q <= alpha;
                  bravo_q <= bravo;
                  wait_q  <= '0;
                  if (cnt_q == '0) acc_op_q <= ACC_SEL_I ? ACC_INIT_I : 32'd0;
                  else             acc_op_q <= acc_q;
               end
            end
            CALC: begin
               wait_q <= wait_q + WAIT_W'(1);
               if (calc_last) begin
                  acc_q <= acc_next;
                  if (last_elem) begin
                     delta_q <= acc_next;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign MAC_READY_O = ready_q;
   assign MAC_VALID_O = valid_q;
   assign delta       = delta_q;
   assign ELEM_CNT_O  = cnt_q;

endmodule

// File: tb/tb_fp32_dot_acc.sv
// Directed bench for fp32_dot_acc: a VEC_LEN=4 instance for vectors, handshakes and reset,
// and a VEC_LEN=1 instance for single-MAC behaviour. Expected values are hand-computed FP32 constants.
module tb_fp32_dot_acc;
   localparam int CALC_WAIT = 4;
   localparam logic [31:0] F_0_5 = 32'h3F000000;
   localparam logic [31:0] F_1   = 32'h3F800000;
   localparam logic [31:0] F_1_5 = 32'h3FC00000;
   localparam logic [31:0] F_2   = 32'h40000000;
   localparam logic [31:0] F_3   = 32'h40400000;
   localparam logic [31:0] F_4   = 32'h40800000;
   localparam logic [31:0] F_M2  = 32'hC0000000;
   localparam logic [31:0] F_5   = 32'h40A00000;
   localparam logic [31:0] F_7   = 32'h40E00000;
   localparam logic [31:0] F_8   = 32'h41000000;
   localparam logic [31:0] F_100 = 32'h42C80000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] alpha = '0, bravo = '0, acc_init = '0;
   logic        acc_sel = 1'b0, elem_valid = 1'b0, res_ready = 1'b0;
   logic        elem_ready, res_valid;
   logic [31:0] delta;
   logic [2:0]  elem_cnt;

   logic [31:0] s_alpha = '0, s_bravo = '0, s_init = '0;
   logic        s_sel = 1'b0, s_elem_valid = 1'b0, s_res_ready = 1'b0;
   logic        s_elem_ready, s_res_valid;
   logic [31:0] s_delta;
   logic [0:0]  s_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp32_dot_acc #(.VEC_LEN(4), .CALC_WAIT(CALC_WAIT)) dut (
      .CLK_I(clk), .RSTL_I(rst_n), .alpha(alpha), .bravo(bravo),
      .ACC_INIT_I(acc_init), .ACC_SEL_I(acc_sel), .MAC_VALID_I(elem_valid),
      .MAC_READY_O(elem_ready), .delta(delta), .MAC_VALID_O(res_valid),
      .MAC_READY_I(res_ready), .ELEM_CNT_O(elem_cnt)
   );

   fp32_dot_acc #(.VEC_LEN(1), .CALC_WAIT(CALC_WAIT)) dut_single (
      .CLK_I(clk), .RSTL_I(rst_n), .alpha(s_alpha), .bravo(s_bravo),
      .ACC_INIT_I(s_init), .ACC_SEL_I(s_sel), .MAC_VALID_I(s_elem_valid),
      .MAC_READY_O(s_elem_ready), .delta(s_delta), .MAC_VALID_O(s_res_valid),
      .MAC_READY_I(s_res_ready), .ELEM_CNT_O(s_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Waits for ready, checks the element count, then offers one element for a single edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sel,
                       input logic [31:0] init, input int idx);
      int n = 0;
      while (elem_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", 32'(elem_ready), 32'd1);
      check("elem_cnt", 32'(elem_cnt), 32'(idx));
      alpha = a; bravo = b; acc_sel = sel; acc_init = init; elem_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      elem_valid = 1'b0;
   endtask

   // Called at the negedge right after the last accept: measures latency and checks delta.
   task automatic wait_result(input string tag, input logic [31:0] exp);
      int n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(CALC_WAIT));
      check({tag, "_delta"}, delta, exp);
      check({tag, "_cnt_clr"}, 32'(elem_cnt), 32'd0);
   endtask

   task automatic handshake(input string tag);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(elem_ready), 32'd1);
   endtask

   task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic sel, input logic [31:0] init, input logic [31:0] exp);
      int n = 0;
      while (s_elem_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(s_elem_ready), 32'd1);
      s_alpha = a; s_bravo = b; s_sel = sel; s_init = init; s_elem_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_elem_valid = 1'b0;
      n = 0;
      while (s_res_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(CALC_WAIT));
      check({tag, "_delta"}, s_delta, exp);
      check({tag, "_cnt"}, 32'(s_cnt), 32'd0);
      s_res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_res_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(s_res_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(elem_ready), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_delta", delta, 32'd0);
      check("rst_cnt", 32'(elem_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(elem_ready), 32'd1);

      // 1*2 + 2*2 + 3*2 + 4*2 = 20.0 from a +0.0 start
      push(F_1, F_2, 1'b0, F_100, 0);
      push(F_2, F_2, 1'b0, F_100, 1);
      push(F_3, F_2, 1'b0, F_100, 2);
      push(F_4, F_2, 1'b0, F_100, 3);
      wait_result("vec_zero", 32'h41A00000);
      handshake("vec_zero");

      // Start at 1.0; select/init on later elements must be ignored -> 21.0
      push(F_1, F_2, 1'b1, F_1, 0);
      push(F_2, F_2, 1'b0, F_100, 1);
      push(F_3, F_2, 1'b1, F_100, 2);
      push(F_4, F_2, 1'b1, F_100, 3);
      wait_result("vec_init", 32'h41A80000);
      handshake("vec_init");

      // 0.5*4 + 1.5*4 - 2*4 + 8*4 = 32.0 (passes through exact zero), then stall in DONE
      push(F_0_5, F_4, 1'b0, '0, 0);
      push(F_1_5, F_4, 1'b0, '0, 1);
      push(F_M2, F_4, 1'b0, '0, 2);
      push(F_8, F_4, 1'b0, '0, 3);
      wait_result("vec_stall", 32'h42000000);
      for (int i = 0; i < 10; i++) begin
         elem_valid = i[0];
         alpha = F_100; bravo = F_100;
         @(negedge clk);
         check("stall_valid", 32'(res_valid), 32'd1);
         check("stall_delta", delta, 32'h42000000);
         check("stall_ready", 32'(elem_ready), 32'd0);
      end
      elem_valid = 1'b0;
      handshake("vec_stall");
      check("stall_no_accept", 32'(elem_cnt), 32'd0);

      // Ties-to-even in the adder: 1 + 2^-24 + 2^-24 + 2^-23 -> 0x3F800001
      push(F_1, F_1, 1'b0, '0, 0);
      push(32'h33800000, F_1, 1'b0, '0, 1);
      push(32'h33800000, F_1, 1'b0, '0, 2);
      push(32'h34000000, F_1, 1'b0, '0, 3);
      wait_result("vec_round", 32'h3F800001);
      handshake("vec_round");

      // Reset after two accepts discards the partial sum
      push(F_5, F_1, 1'b0, '0, 0);
      push(F_7, F_1, 1'b0, '0, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_cnt", 32'(elem_cnt), 32'd0);
      check("midrst_valid", 32'(res_valid), 32'd0);
      check("midrst_ready", 32'(elem_ready), 32'd0);
      check("midrst_delta", delta, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(F_1, F_2, 1'b0, '0, 0);
      push(F_2, F_2, 1'b0, '0, 1);
      push(F_3, F_2, 1'b0, '0, 2);
      push(F_4, F_2, 1'b0, '0, 3);
      wait_result("vec_after_rst", 32'h41A00000);
      handshake("vec_after_rst");

      // Valid held high: one accept per IDLE visit, count steps 0,1,2,3 then 0
      alpha = F_1; bravo = F_1; acc_sel = 1'b0; elem_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int n = 0;
         while (elem_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("hold_cnt", 32'(elem_cnt), 32'(i));
         @(posedge clk);
         @(negedge clk);
         check("hold_one_accept", 32'(elem_ready), 32'd0);
      end
      wait_result("vec_hold", F_4);
      repeat (3) begin
         @(negedge clk);
         check("hold_done_ready", 32'(elem_ready), 32'd0);
      end
      elem_valid = 1'b0;
      handshake("vec_hold");
      check("hold_cnt_end", 32'(elem_cnt), 32'd0);

      // Single-MAC instance: every accept yields its own result
      run_single("single_a", F_3, F_4, 1'b0, '0, 32'h41400000);
      run_single("single_b", F_3, F_4, 1'b0, F_100, 32'h41400000);
      run_single("single_init", F_3, F_4, 1'b1, F_1, 32'h41500000);
      run_single("single_mulrnd", 32'h3F800001, 32'h3F800001, 1'b0, '0, 32'h3F800002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
